// File: rtl/bus_dev_pkg.sv
// Shared definitions for the bus device port: address field helpers,
// the default broadcast address and the saturating counter step.
package bus_dev_pkg;

   localparam int DEST_W      = 8;
   localparam int MAX_PCKG_SZ = 64;

   localparam logic [DEST_W-1:0] BROADCAST = 8'hFF;

   // Destination address lives in the top DEST_W bits of the packet.
   function automatic logic [DEST_W-1:0] dest_of(input logic [MAX_PCKG_SZ-1:0] pkt,
                                                 input int unsigned            pckg_sz);
      return DEST_W'(pkt >> (pckg_sz - DEST_W));
   endfunction

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count.
// A write while full is still taken when a read retires the head in
// the same cycle; reads on an empty FIFO are ignored.
module bus_sync_fifo #(
   parameter int width = 16,
   parameter int depth = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [width-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [width-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(depth):0]   count
);

   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;

   logic [width-1:0] mem_q [depth];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_ok, rd_ok;

   assign full    = (count_q == CW'(depth));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);
   // Head is shown straight from storage; forced to zero when nothing is held.
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   // Next pointer and occupancy values from the accepted read/write strobes.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset since occupancy gates the output.
   always_ff @(posedge clk) begin
      if (reset && wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/bus_device_port.sv
// Device endpoint for the bus arbiter: TX FIFO feeding pndng/D_pop,
// RX FIFO behind a destination filter, plus saturating drop counters.
module bus_device_port
   import bus_dev_pkg::*;
#(
   parameter int          pckg_sz   = 16,
   parameter int          deep_fifo = 8,
   parameter logic [7:0]  id        = 8'd0,
   parameter logic [7:0]  broadcast = BROADCAST
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tx_push,
   input  logic [pckg_sz-1:0] tx_data,
   output logic               tx_full,
   output logic               pndng,
   output logic [pckg_sz-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   output logic               rx_pndng,
   output logic [pckg_sz-1:0] rx_data,
   input  logic               rx_pop,
   output logic [7:0]         tx_ovf_cnt,
   output logic [7:0]         rx_drop_cnt,
   output logic [7:0]         rx_miss_cnt
);

   localparam int CW = $clog2(deep_fifo) + 1;

   logic          tx_full_w, tx_empty_w;
   logic          rx_full_w, rx_empty_w;
   logic [CW-1:0] tx_count_w, rx_count_w;
   logic          unused_count;
   logic [7:0]    rx_dest;
   logic          rx_match;
   logic [7:0]    tx_ovf_q, tx_ovf_d;
   logic [7:0]    rx_drop_q, rx_drop_d;
   logic [7:0]    rx_miss_q, rx_miss_d;

   assign rx_dest  = dest_of(MAX_PCKG_SZ'(D_push), pckg_sz);
   assign rx_match = (rx_dest == id) || (rx_dest == broadcast);

   bus_sync_fifo #(.width(pckg_sz), .depth(deep_fifo)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (tx_push),
      .wr_data (tx_data),
      .rd_en   (pop),
      .rd_data (D_pop),
      .full    (tx_full_w),
      .empty   (tx_empty_w),
      .count   (tx_count_w)
   );

   bus_sync_fifo #(.width(pckg_sz), .depth(deep_fifo)) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push && rx_match),
      .wr_data (D_push),
      .rd_en   (rx_pop),
      .rd_data (rx_data),
      .full    (rx_full_w),
      .empty   (rx_empty_w),
      .count   (rx_count_w)
   );

   // Occupancy counts are only observed in simulation; flags cover the logic.
   assign unused_count = ^{tx_count_w, rx_count_w};

   assign tx_full  = tx_full_w;
   assign pndng    = !tx_empty_w;
   assign rx_pndng = !rx_empty_w;

   // Bump the drop/miss counters on the cycle the packet is lost.
   always_comb begin
      tx_ovf_d  = tx_ovf_q;
      rx_drop_d = rx_drop_q;
      rx_miss_d = rx_miss_q;
      if (tx_push && tx_full_w && !pop)           tx_ovf_d  = sat_inc(tx_ovf_q);
      if (push && rx_match && rx_full_w && !rx_pop) rx_drop_d = sat_inc(rx_drop_q);
      if (push && !rx_match)                      rx_miss_d = sat_inc(rx_miss_q);
   end

   // Counter registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_ovf_q  <= '0;
         rx_drop_q <= '0;
         rx_miss_q <= '0;
      end else begin
         tx_ovf_q  <= tx_ovf_d;
         rx_drop_q <= rx_drop_d;
         rx_miss_q <= rx_miss_d;
      end
   end

   assign tx_ovf_cnt  = tx_ovf_q;
   assign rx_drop_cnt = rx_drop_q;
   assign rx_miss_cnt = rx_miss_q;

endmodule

// File: doc/bus_device_port.md
# bus_device_port

Device-side endpoint of the bus generator/arbiter protocol: the block that sits at one driver position and answers the arbiter's `pop`/`push` strobes. A local TX FIFO presents `pndng`/`D_pop` to the arbiter. A local RX FIFO captures packets the arbiter delivers via `push`/`D_push`, with destination filtering. One instance per driver; it replaces the behavioural FIFO model on the synthesizable side.

## Interface
- `pckg_sz`, 16: packet width in bits; must be at least 9.
- `deep_fifo`, 8: depth of each FIFO; power of two, at least 2.
- `id`, 0: this device's 8-bit address.
- `broadcast`, 8'hFF: destination value accepted by every device.

- `clk`  in  1: clock, rising edge.
- `reset`  in  1: synchronous, active-low.
- `tx_push`  in  1: local write into the TX FIFO.
- `tx_data`  in  pckg_sz: local TX packet.
- `tx_full`  out  1: TX FIFO full.
- `pndng`  out  1: TX FIFO non-empty, seen by the arbiter.
- `D_pop`  out  pckg_sz: TX head packet (first-word fall-through).
- `pop`  in  1: arbiter consumes the TX head.
- `push`  in  1: arbiter delivers a packet.
- `D_push`  in  pckg_sz: delivered packet.
- `rx_pndng`  out  1: RX FIFO non-empty.
- `rx_data`  out  pckg_sz: RX head packet (first-word fall-through).
- `rx_pop`  in  1: local read of the RX head.
- `tx_ovf_cnt`  out  8: count of TX writes dropped because the FIFO was full; saturating.
- `rx_drop_cnt`  out  8: count of RX packets dropped because the FIFO was full; saturating.
- `rx_miss_cnt`  out  8: count of RX packets dropped on address mismatch; saturating.

## Operation
- Packet destination field is `[pckg_sz-1 : pckg_sz-8]`; the payload is the remaining bits. The block never alters packet contents.
- TX FIFO write: `tx_push` with `tx_full`=0 stores `tx_data`.
- TX write on full:
  - With `pop` in the same cycle, the write is accepted.
  - Otherwise the packet is dropped and `tx_ovf_cnt` increments.
- TX FIFO read: `pop` with `pndng`=1 advances the head. `pop` with `pndng`=0 is ignored, with no state change and no counter change.
- RX accept: `push`=1 and the destination equals `id` or `broadcast`.
  - Not full: the packet is stored.
  - Full with `rx_pop` in the same cycle: the packet is stored.
  - Full without `rx_pop`: the packet is dropped and `rx_drop_cnt` increments.
- RX reject: `push`=1 with any other destination drops the packet and increments `rx_miss_cnt`. It never touches the FIFO.
- `rx_pop` with `rx_pndng`=0 is ignored.
- Pointers: read and write pointers are `$clog2(deep_fifo)` bits and wrap modulo `deep_fifo`. The occupancy count is `$clog2(deep_fifo)+1` bits.
  - full = (count == deep_fifo)
  - empty = (count == 0)
  - Simultaneous write and read leaves the count unchanged.
- All counters saturate at 8'hFF and never wrap.

## Timing
- Reset is `reset`=0 sampled at a rising edge. Required state after reset:
  - Both FIFOs empty.
  - `pndng`, `rx_pndng` and `tx_full` = 0.
  - All counters = 0.
  - `D_pop` and `rx_data` = 0.
- Reset asserted mid-operation flushes both FIFOs in that cycle. Strobes in the reset cycle are ignored.
- Write-to-visible latency is 1 cycle: a write at edge N gives `pndng`/`rx_pndng`=1 and valid head data after edge N.
- Pop latency: a pop at edge N presents the next head after edge N. If that was the last entry, the pending flag drops after edge N.
- `D_pop`/`rx_data` are combinational from the storage read pointer. They are 0 when empty.
- `tx_full` and the pending flags are registered-state derived, with no input-to-output combinational path. The arbiter may sample `pndng` and issue `pop` in the same cycle.
- Counters update at the edge that causes the drop.

## Structure
- Package `bus_dev_pkg` holds:
  - `DEST_W` = 8
  - the `dest_of()` function, which extracts `[pckg_sz-1 -: 8]`
  - the default `BROADCAST` = 8'hFF
  - the saturating-increment function
- One sub-module, `bus_sync_fifo` (parameters `width`, `depth`): first-word fall-through, active-low synchronous reset, with `full`/`empty`/`count`. It is instantiated twice, once for TX and once for RX.
- Address filter and counters live in the top level.

## Test plan
- Reset, then `tx_push` 16'h0155 and 16'h02AA on consecutive cycles -> `pndng`=1 one cycle later with `D_pop`=16'h0155. `pop` gives 16'h02AA, then `pndng`=0.
- With `id`=3: `push` 16'h0311, 16'hFF22 and 16'h0533 -> `rx_data` sequence 16'h0311, 16'hFF22. `rx_miss_cnt`=1.
- TX overflow: write `deep_fifo`+2 packets with no pop -> `tx_full`=1 and `tx_ovf_cnt`=2. Then a push plus pop in the same cycle while full -> accepted, count unchanged, `tx_ovf_cnt` stays 2.
- RX full: fill 8 entries, push 2 more matching packets -> `rx_drop_cnt`=2. Drain 8 entries in order; the pointer wraps correctly when 8 more are refilled.
- Saturation and stray strobes: 300 mismatched pushes -> `rx_miss_cnt`=8'hFF. `pop`/`rx_pop` on empty -> no change.
- Reset mid-stream with 5 entries in each FIFO -> next cycle both pending flags 0, all counters 0, and data outputs 0.
